// File: rtl/ttl74x153_dual_mux4.sv
// 74x153 dual 4-to-1 data selector: two muxes share one select and each has its own active-low strobe.
// The combinational outputs follow the datasheet; y1_q/y2_q are one-cycle registered copies.
module ttl74x153_dual_mux4 (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic enable1,
  input  logic enable2,
  input  logic c10,
  input  logic c11,
  input  logic c12,
  input  logic c13,
  input  logic c20,
  input  logic c21,
  input  logic c22,
  input  logic c23,
  output logic y1,
  output logic y2,
  output logic y1_q,
  output logic y2_q
);

  logic [1:0] sel;
  logic [3:0] c1;
  logic [3:0] c2;
  logic       y1_d;
  logic       y2_d;

  assign sel = {b, a};
  assign c1  = {c13, c12, c11, c10};
  assign c2  = {c23, c22, c21, c20};

  // A variable index lets an X/Z select propagate as X instead of falling into a default branch.
  // NOTE: every path assigns y1/y2, so this logic cannot infer a latch.
  always_comb begin
    y1 = 1'b0;
    y2 = 1'b0;
    if (!enable1) y1 = c1[sel];
    if (!enable2) y2 = c2[sel];
  end

  assign y1_d = y1;
  assign y2_d = y2;

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      y1_q <= 1'b0;
      y2_q <= 1'b0;
    end else begin
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

endmodule

// File: tb/tb_ttl74x153_dual_mux4.sv
// Directed and exhaustive checks of the 74x153 combinational outputs and their registered copies.
module tb_ttl74x153_dual_mux4;

  logic clk = 1'b0;
  logic rst;
  logic a, b, enable1, enable2;
  logic c10, c11, c12, c13, c20, c21, c22, c23;
  logic y1, y2, y1_q, y2_q;

  int total = 0;
  int bad   = 0;

  ttl74x153_dual_mux4 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .enable1(enable1), .enable2(enable2),
    .c10(c10), .c11(c11), .c12(c12), .c13(c13),
    .c20(c20), .c21(c21), .c22(c22), .c23(c23),
    .y1(y1), .y2(y2), .y1_q(y1_q), .y2_q(y2_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive sel={b,a}, strobes and both data nibbles (bit n = Cxn).
  task automatic apply(input logic [1:0] s, input logic e1, input logic e2,
                       input logic [3:0] d1, input logic [3:0] d2);
    {b, a} = s;
    enable1 = e1;
    enable2 = e2;
    {c13, c12, c11, c10} = d1;
    {c23, c22, c21, c20} = d2;
  endtask

  function automatic logic ref_mux(input logic en_n, input logic bb, input logic aa,
                                   input logic [3:0] d);
    if (en_n) return 1'b0;
    if (!bb) return aa ? d[1] : d[0];
    return aa ? d[3] : d[2];
  endfunction

  initial begin
    rst = 1'b1;
    apply(2'b00, 1'b1, 1'b1, 4'h0, 4'h0);

    // Reset state.
    @(posedge clk); #1;
    check("reset_y1_q", y1_q, 1'b0);
    check("reset_y2_q", y2_q, 1'b0);
    check("reset_y1", y1, 1'b0);
    check("reset_y2", y2, 1'b0);

    // Select sweep: one-hot data on mux 1, y1 high only when sel hits the hot input.
    for (int hot = 0; hot < 4; hot++) begin
      for (int s = 0; s < 4; s++) begin
        apply(s[1:0], 1'b0, 1'b0, 4'(1 << hot), 4'h0);
        #1;
        check($sformatf("sweep_hot%0d_sel%0d", hot, s), y1, (hot == s) ? 1'b1 : 1'b0);
        check($sformatf("sweep_y2_hot%0d_sel%0d", hot, s), y2, 1'b0);
      end
    end

    // Mux 2 with all mux-1 data high.
    apply(2'b00, 1'b0, 1'b0, 4'hF, 4'b0001); #1;
    check("m2_sel0_y1", y1, 1'b1);
    check("m2_sel0_y2", y2, 1'b1);
    apply(2'b01, 1'b0, 1'b0, 4'hF, 4'b0001); #1;
    check("m2_sel1_y2", y2, 1'b0);
    apply(2'b10, 1'b0, 1'b0, 4'hF, 4'b0100); #1;
    check("m2_sel2_y2", y2, 1'b1);

    // Strobe gating, all data high, sel=11.
    apply(2'b11, 1'b1, 1'b1, 4'hF, 4'hF); #1;
    check("strobe11_y1", y1, 1'b0);
    check("strobe11_y2", y2, 1'b0);
    apply(2'b11, 1'b0, 1'b1, 4'hF, 4'hF); #1;
    check("strobe01_y1", y1, 1'b1);
    check("strobe01_y2", y2, 1'b0);
    apply(2'b11, 1'b1, 1'b0, 4'hF, 4'hF); #1;
    check("strobe10_y1", y1, 1'b0);
    check("strobe10_y2", y2, 1'b1);

    // Registered path.
    @(negedge clk);
    rst = 1'b0;
    apply(2'b00, 1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge clk); #1;
    check("reg_idle_y1_q", y1_q, 1'b0);
    @(negedge clk);
    apply(2'b11, 1'b0, 1'b0, 4'b1000, 4'b0000); #1;
    check("reg_pre_y1", y1, 1'b1);
    check("reg_pre_y1_q_hold", y1_q, 1'b0);
    @(posedge clk); #1;
    check("reg_load_y1_q", y1_q, 1'b1);
    check("reg_load_y2_q", y2_q, 1'b0);
    @(negedge clk);
    apply(2'b11, 1'b0, 1'b0, 4'b1000, 4'b1000);
    @(posedge clk); #1;
    check("reg_load2_y2_q", y2_q, 1'b1);

    // Synchronous reset mid-operation; combinational path keeps tracking.
    @(negedge clk);
    rst = 1'b1; #1;
    check("rst_pre_y1_q", y1_q, 1'b1);
    @(posedge clk); #1;
    check("rst_y1_q", y1_q, 1'b0);
    check("rst_y2_q", y2_q, 1'b0);
    check("rst_y1_live", y1, 1'b1);
    check("rst_y2_live", y2, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_y1_q", y1_q, 1'b1);
    check("release_y2_q", y2_q, 1'b1);

    // Exhaustive sweep of all 12 inputs against the reference equations.
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = 12'(i);
      apply(v[9:8], v[10], v[11], v[3:0], v[7:4]);
      #1;
      check($sformatf("exh_y1_%03h", v), y1, ref_mux(v[10], v[9], v[8], v[3:0]));
      check($sformatf("exh_y2_%03h", v), y2, ref_mux(v[11], v[9], v[8], v[7:4]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
